// File: rtl/mac_pe.sv
// Streaming unsigned multiply-accumulate element: forms N dot products of a
// run-time length per job and emits one saturated NUM_BITS result per dot.
package pkg;
   parameter int NUM_BITS = 8;
   parameter int N        = 4;
endpackage

// state | meaning
// IDLE  | waiting for start_i with a non-zero length; operands refused
// RUN   | accepting operand pairs, counting terms and dot products
// DRAIN | two cycles for the multiply/accumulate pipeline to empty
// DONE  | done_o pulse, then back to IDLE
module mac_pe #(
   parameter int NUM_BITS = pkg::NUM_BITS,
   parameter int N        = pkg::N,
   parameter int K        = 8,
   parameter int LEN_W    = $clog2(K+1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [LEN_W-1:0]    len_i,
   input  logic                clear_i,
   input  logic [NUM_BITS-1:0] a_i,
   input  logic [NUM_BITS-1:0] b_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic [NUM_BITS-1:0] c_o,
   output logic                c_valid_o,
   output logic                c_sat_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int PW    = 2*NUM_BITS;
   localparam int ACC_W = 2*NUM_BITS + $clog2(K);
   localparam int DOT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(K);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(N-1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic                drain_q;
   logic [LEN_W-1:0]    len_q, term_cnt;
   logic [DOT_W-1:0]    dot_cnt;
   logic                beat, last_beat, job_last, start_ok;
   logic [PW-1:0]       p_q;
   logic                p_vld, p_last;
   logic [ACC_W-1:0]    acc, sum;

   assign start_ok  = (state_q == IDLE) && start_i && (len_i != '0);
   assign beat      = in_valid_i && in_ready_o;
   assign last_beat = beat && (term_cnt == len_q - LEN_ONE);
   assign job_last  = last_beat && (dot_cnt == DOT_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= (state_q == DRAIN) && !clear_i;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (job_last) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready_o = (state_q == RUN);
      busy_o     = (state_q != IDLE);
      done_o     = (state_q == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         len_q    <= '0;
         term_cnt <= '0;
         dot_cnt  <= '0;
      end else if (clear_i) begin
         term_cnt <= '0;
         dot_cnt  <= '0;
      end else if (start_ok) begin
         len_q    <= (len_i > LEN_MAX) ? LEN_MAX : len_i;
         term_cnt <= '0;
         dot_cnt  <= '0;
      end else if (beat) begin
         if (last_beat) begin
            term_cnt <= '0;
            dot_cnt  <= dot_cnt + DOT_W'(1);
         end else begin
            term_cnt <= term_cnt + LEN_ONE;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_q    <= '0;
         p_vld  <= 1'b0;
         p_last <= 1'b0;
      end else if (clear_i) begin
         p_vld  <= 1'b0;
         p_last <= 1'b0;
      end else begin
         p_vld  <= beat;
         p_last <= last_beat;
         if (beat) p_q <= PW'(a_i) * PW'(b_i);
      end
   end

   // acc is wide enough for K full-scale products, so only the output saturates
   assign sum = acc + ACC_W'(p_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc       <= '0;
         c_o       <= '0;
         c_sat_o   <= 1'b0;
         c_valid_o <= 1'b0;
      end else if (clear_i) begin
         acc       <= '0;
         c_valid_o <= 1'b0;
      end else begin
         c_valid_o <= 1'b0;
         if (p_vld) begin
            if (p_last) begin
               acc       <= '0;
               c_valid_o <= 1'b1;
               if (|sum[ACC_W-1:NUM_BITS]) begin
                  c_o     <= '1;
                  c_sat_o <= 1'b1;
               end else begin
                  c_o     <= sum[NUM_BITS-1:0];
                  c_sat_o <= 1'b0;
               end
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule

// File: doc/mac_pe.md
# mac_pe

- Upstream multiply-accumulate stage of the systolic C datapath.
- Consumes streamed A/B operand pairs, forms unsigned dot products of a run-time length, and delivers one NUM_BITS result per dot product as a one-cycle `c_valid_o` pulse.
- Each job produces exactly N results, so one job fills the downstream N-deep result shift register (`C_i`/`valid_i`) exactly once.

## Interface
- `NUM_BITS`, default `pkg::NUM_BITS`: operand and result width.
- `N`, default `pkg::N`: dot products per job, matching the downstream register depth.
- `K`, default 8: maximum terms per dot product; `LEN_W = $clog2(K+1)`.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `start_i`  in  1  start a job; sampled only in IDLE.
- `len_i`  in  LEN_W  terms per dot product; latched on accepted start.
- `clear_i`  in  1  synchronous abort; higher priority than all other inputs.
- `a_i`, `b_i`  in  NUM_BITS each  operand pair.
- `in_valid_i`  in  1  operand pair valid.
- `in_ready_o`  out  1  operand pair can be accepted.
- `c_o`  out  NUM_BITS  dot-product result; feeds downstream `C_i`.
- `c_valid_o`  out  1  one-cycle result strobe; feeds downstream `valid_i`.
- `c_sat_o`  out  1  `c_o` was saturated; meaningful only with `c_valid_o`.
- `busy_o`  out  1  state is not IDLE.
- `done_o`  out  1  one-cycle pulse when a job completes.

## Operation
- **Beat:** `in_valid_i && in_ready_o` at a rising edge.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `in_ready_o = 0`.
  - `start_i` with `len_i != 0` latches `len = min(len_i, K)`, clears `term_cnt` and `dot_cnt`, and moves to RUN.
  - `start_i` with `len_i == 0` is ignored.
- **RUN:**
  - `in_ready_o = 1`.
  - Each beat increments `term_cnt`.
  - The beat with `term_cnt == len-1` is tagged last; `term_cnt` returns to 0 and `dot_cnt` increments.
  - The last beat of dot `N-1` moves the FSM to DRAIN.
- **DRAIN:**
  - `in_ready_o = 0`.
  - Lasts exactly 2 cycles while the pipeline empties, then moves to DONE.
- **DONE:** `done_o = 1` for one cycle, then IDLE.
- **Pipeline stage 1:** on a beat, `p_q <= a_i*b_i` (2*NUM_BITS wide), together with `p_vld` and `p_last` flags.
- **Pipeline stage 2:**
  - When `p_vld` is set, `sum = acc + p_q`, where `acc` is `2*NUM_BITS + $clog2(K)` bits wide (no internal overflow).
  - If `p_last`: `acc <= 0`; `c_o` gets `sum` if `sum <= 2^NUM_BITS-1`, otherwise all ones with `c_sat_o = 1`; `c_valid_o <= 1`.
  - Otherwise `acc <= sum`.
- **Back-to-back dot products:** no bubble is required; the first product of the next dot product accumulates from 0.
- **Arithmetic:** all unsigned.
- **clear_i:** from any state, the next state is IDLE.
  - Clears `p_vld`, `acc`, and both counters.
  - Suppresses any pending `c_valid_o` and `done_o`.
  - `c_o` and `c_sat_o` retain their values.
- **start_i outside IDLE:** ignored.

## Timing
- **Reset values:** every output is 0; state is IDLE, and `acc`, `p_q`, and the counters are 0. `c_o` stays 0 until the first result.
- **Beat cycle:** a beat in cycle t is the edge at the end of t.
- **Result latency:** last beat of a dot product in cycle t → `c_valid_o` high in cycle t+2 for exactly one cycle. `c_o` is updated in the same cycle and holds until the next result.
- **Job completion:** last beat of the job in cycle t →
  - DRAIN in t+1 and t+2;
  - final `c_valid_o` in t+2;
  - `done_o` in t+3;
  - IDLE (`busy_o = 0`) in t+4.
- **Start:** `start_i` in cycle t while IDLE → `busy_o` and `in_ready_o` high in t+1.
- **Throughput:** one beat per cycle; gaps in `in_valid_i` do not change the results.
- **clear_i:** asserted in cycle t → `in_ready_o` and `busy_o` are 0 in t+1, with no `c_valid_o` or `done_o` in t+1 or later from the aborted job.
- **Reset mid-operation:** `rst_ni` low forces the reset values immediately, independent of `clk_i`.

## Test plan
Bench configuration: N=4, NUM_BITS=8, K=8.
- **Reset:** assert `rst_ni` low mid-RUN between edges → all outputs 0 immediately. After release, IDLE with `in_ready_o = 0`.
- **Basic job:** start with `len_i = 3`; feed `a = 1, 2, 3` and `b = 2` continuously for 4 dot products → 4 `c_valid_o` pulses, each `c_o = 12`, `c_sat_o = 0`. Each pulse comes 2 cycles after that dot product's last beat; `done_o` comes 3 cycles after the 12th beat.
- **Saturation:** `len_i = 8`, `a = b = 255` → `c_o = 255`, `c_sat_o = 1`. A following dot product with `a = b = 1`, `len = 8` gives `c_o = 8`, `c_sat_o = 0`.
- **Gaps and clamping:** `len_i = 15` is clamped to 8. Random `in_valid_i` gaps with `a = 3`, `b = 4` → every `c_o = 96`, and exactly 32 beats are accepted.
- **Abort:** `clear_i` after 5 beats of a `len = 3` job → exactly one `c_valid_o` (12), no `done_o`, IDLE next cycle. A fresh `len = 1` job with `a = b = 2` → `c_o = 4` ×4.
- **Ignored inputs:** `start_i` with `len_i = 0` and `start_i` during RUN are both ignored → state and counters unchanged.
